// File: rtl/cla_avalon_arbiter.sv
// Round-robin arbiter that lets two requesters share one carry_lookahead_adder slave.
// Each grant runs a fixed sequence on the adder bus: write A, write B, read the sum, capture it, pulse done.
module cla_avalon_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0,
    input  logic [DATA_WIDTH-1:0] a0,
    input  logic [DATA_WIDTH-1:0] b0,
    output logic                  done0,
    output logic [DATA_WIDTH-1:0] result0,
    input  logic                  req1,
    input  logic [DATA_WIDTH-1:0] a1,
    input  logic [DATA_WIDTH-1:0] b1,
    output logic                  done1,
    output logic [DATA_WIDTH-1:0] result1,
    output logic                  busy,
    output logic                  CS,
    output logic                  WR,
    output logic                  RD,
    output logic                  Address,
    output logic [DATA_WIDTH-1:0] Data,
    input  logic [DATA_WIDTH-1:0] o_result
);

    // Requester handshake: reqN is a level sampled only in IDLE; doneN is a one-cycle
    // pulse in DONE with resultN valid from then until the next doneN. The requester
    // must drop reqN by the edge after doneN, or it is taken as a new request.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_A    = 3'd1,
        WR_B    = 3'd2,
        RD_SUM  = 3'd3,
        CAPTURE = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic                  last_q, last_d;
    logic                  grant_q, grant_d;
    logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
    logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
    logic [DATA_WIDTH-1:0] result0_q, result0_d;
    logic [DATA_WIDTH-1:0] result1_q, result1_d;
    logic                  done0_q, done0_d;
    logic                  done1_q, done1_d;
    logic                  busy_q, busy_d;
    logic                  cs_q, cs_d;
    logic                  wr_q, wr_d;
    logic                  rd_q, rd_d;
    logic                  addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  pick;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            grant_q   <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            result0_q <= '0;
            result1_q <= '0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            busy_q    <= 1'b0;
            cs_q      <= 1'b0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            addr_q    <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            result0_q <= result0_d;
            result1_q <= result1_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            busy_q    <= busy_d;
            cs_q      <= cs_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    // Bus outputs are registered, so each branch computes the strobes for the state being entered.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        grant_d   = grant_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        result0_d = result0_q;
        result1_d = result1_q;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        cs_d      = 1'b0;
        wr_d      = 1'b0;
        rd_d      = 1'b0;
        addr_d    = 1'b0;
        data_d    = '0;
        pick      = (req0 && req1) ? ~last_q : req1;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    grant_d = pick;
                    op_a_d  = pick ? a1 : a0;
                    op_b_d  = pick ? b1 : b0;
                    state_d = WR_A;
                    cs_d    = 1'b1;
                    wr_d    = 1'b1;
                    data_d  = pick ? a1 : a0;
                end
            end
            WR_A: begin
                state_d = WR_B;
                cs_d    = 1'b1;
                wr_d    = 1'b1;
                addr_d  = 1'b1;
                data_d  = op_b_q;
            end
            WR_B: begin
                state_d = RD_SUM;
                cs_d    = 1'b1;
                rd_d    = 1'b1;
            end
            RD_SUM: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                state_d = DONE;
                last_d  = grant_q;
                if (grant_q) begin
                    result1_d = o_result;
                    done1_d   = 1'b1;
                end else begin
                    result0_d = o_result;
                    done0_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign done0   = done0_q;
    assign done1   = done1_q;
    assign result0 = result0_q;
    assign result1 = result1_q;
    assign busy    = busy_q;
    assign CS      = cs_q;
    assign WR      = wr_q;
    assign RD      = rd_q;
    assign Address = addr_q;
    assign Data    = data_q;

endmodule

// File: tb/tb_cla_avalon_arbiter.sv
// Directed bench for cla_avalon_arbiter: a behavioural adder slave, a done scoreboard
// and a bus-transaction scoreboard, each fed from the stimulus and popped by monitors.
module tb_cla_avalon_arbiter;

  localparam int W = 32;

  logic         clock;
  logic         reset;
  logic         req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         done0, done1;
  logic [W-1:0] result0, result1;
  logic         busy;
  logic         CS, WR, RD, Address;
  logic [W-1:0] Data;
  logic [W-1:0] o_result;

  cla_avalon_arbiter #(.DATA_WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .req0     (req0),
    .a0       (a0),
    .b0       (b0),
    .done0    (done0),
    .result0  (result0),
    .req1     (req1),
    .a1       (a1),
    .b1       (b1),
    .done1    (done1),
    .result1  (result1),
    .busy     (busy),
    .CS       (CS),
    .WR       (WR),
    .RD       (RD),
    .Address  (Address),
    .Data     (Data),
    .o_result (o_result)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- adder slave ----------------
  logic [W-1:0] add_a = '0;
  logic [W-1:0] add_b = '0;
  initial o_result = '0;
  always @(posedge clock) begin
    if (CS && WR) begin
      if (Address) add_b <= Data;
      else         add_a <= Data;
    end
    if (CS && RD) o_result <= add_a + add_b;
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [W:0]   exp_q[$];     // {requester index, sum}
  logic [W+2:0] bus_q[$];     // {WR, RD, Address, Data}
  int n_done0 = 0;
  int n_done1 = 0;
  int done0_cyc = 0;
  int done1_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // done monitor
  always @(negedge clock) begin
    logic [W:0] e;
    if (!reset && (done0 || done1)) begin
      if (done0) begin n_done0++; done0_cyc = cyc; end
      if (done1) begin n_done1++; done1_cyc = cyc; end
      check("done_exclusive", {done0, done1} == 2'b11, 1'b0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", {done1, done0}, 2'b00);
      end else begin
        e = exp_q.pop_front();
        check("done_result", {done1, done1 ? result1 : result0}, e);
      end
    end
  end

  // bus monitor
  always @(negedge clock) begin
    logic [W+2:0] e;
    if (!reset) begin
      if (CS) begin
        if (bus_q.size() == 0) begin
          check("unexpected_bus", {WR, RD, Address, Data}, '0);
        end else begin
          e = bus_q.pop_front();
          check("bus_txn", {WR, RD, Address, Data}, e);
        end
      end else begin
        check("bus_idle", {WR, RD, Address, Data}, '0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push_op(input logic idx, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] s;
    s = a + b;
    exp_q.push_back({idx, s});
    bus_q.push_back({1'b1, 1'b0, 1'b0, a});
    bus_q.push_back({1'b1, 1'b0, 1'b1, b});
    bus_q.push_back({1'b0, 1'b1, 1'b0, {W{1'b0}}});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus_q.size() != 0 || busy) && n < 60) begin
      tick(1);
      n++;
    end
    check({name, "_timeout"}, n >= 60, 1'b0);
    if (n >= 60) begin
      exp_q.delete();
      bus_q.delete();
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, {busy, done0, done1, CS, WR, RD, Address}, 7'b0);
    check({name, "_data"}, Data, 0);
    check({name, "_res0"}, result0, 0);
    check({name, "_res1"}, result1, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int snap0, snap1;
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    tick(2);
    check_all_zero("reset_state");
    reset = 1'b0;
    tick(1);
    check_all_zero("after_release");

    // single request from requester 0
    snap1 = n_done1;
    a0 = 32'd10; b0 = 32'd255; req0 = 1'b1;
    push_op(1'b0, a0, b0);
    tick(1);
    req0 = 1'b0;
    drain("single");
    check("single_res0", result0, 32'd265);
    check("single_res1", result1, 0);
    check("single_no_done1", n_done1 - snap1, 0);

    // tie right after reset: requester 0 first, requester 1 six cycles later
    do_reset();
    a0 = 32'd1; b0 = 32'd2; a1 = 32'd3; b1 = 32'd4;
    req0 = 1'b1; req1 = 1'b1;
    push_op(1'b0, 32'd1, 32'd2);
    push_op(1'b1, 32'd3, 32'd4);
    tick(1);
    req0 = 1'b0;
    tick(6);
    req1 = 1'b0;
    drain("tie");
    check("tie_res0", result0, 32'd3);
    check("tie_res1", result1, 32'd7);
    check("tie_spacing", done1_cyc - done0_cyc, 6);

    // wrap-around on requester 1
    a1 = 32'hFFFF_FFFF; b1 = 32'h1; req1 = 1'b1;
    push_op(1'b1, a1, b1);
    tick(1);
    req1 = 1'b0;
    drain("wrap1");
    check("wrap1_res1", result1, 0);
    a1 = 32'h8000_0000; b1 = 32'h8000_0000; req1 = 1'b1;
    push_op(1'b1, a1, b1);
    tick(1);
    req1 = 1'b0;
    drain("wrap2");
    check("wrap2_res1", result1, 0);
    check("wrap_res0_kept", result0, 32'd3);

    // operand change and request drop after grant
    snap0 = n_done0;
    a0 = 32'd5; b0 = 32'd6; req0 = 1'b1;
    push_op(1'b0, 32'd5, 32'd6);
    tick(2);
    a0 = 32'd100; req0 = 1'b0;
    drain("midchange");
    check("midchange_res0", result0, 32'd11);
    check("midchange_done0", n_done0 - snap0, 1);

    // reset in WR_B: outputs clear at once, no done for the aborted op
    do_reset();
    snap0 = n_done0;
    a0 = 32'd7; b0 = 32'd8; req0 = 1'b1;
    bus_q.push_back({1'b1, 1'b0, 1'b0, 32'd7});
    tick(1);
    req0 = 1'b0;
    tick(1);
    check("wrb_cs", {CS, WR, Address}, 3'b111);
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    tick(1);
    reset = 1'b0;
    tick(1);
    check("abort_no_done0", n_done0 - snap0, 0);
    check("abort_bus_q", bus_q.size(), 0);
    a1 = 32'd20; b1 = 32'd22; req1 = 1'b1;
    push_op(1'b1, a1, b1);
    tick(1);
    req1 = 1'b0;
    drain("post_reset");
    check("post_reset_res1", result1, 32'd42);
    check("post_reset_res0", result0, 0);
    check("post_reset_no_done0", n_done0 - snap0, 0);

    // back-to-back fairness: last served is 1, so order is 0,1,0,1
    a0 = 32'd11; b0 = 32'd22; a1 = 32'd100; b1 = 32'd200;
    req0 = 1'b1; req1 = 1'b1;
    push_op(1'b0, a0, b0);
    push_op(1'b1, a1, b1);
    push_op(1'b0, a0, b0);
    push_op(1'b1, a1, b1);
    for (int k = 1; k <= 24; k++) begin
      tick(1);
      if (k <= 23) check($sformatf("busy_c%0d", k), busy, (k % 6) != 0);
      if (k == 19) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
    drain("fair");
    check("fair_res0", result0, 32'd33);
    check("fair_res1", result1, 32'd300);

    tick(3);
    check("final_idle", busy, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
